duty_ramp_ctrl: RTL and testbench

Soft-start and soft-stop sequencer for the DC motor/generator PWM stage. It generates the 10-bit duty word and the enable for the PWM. The duty word ramps toward a commanded target by a fixed step once per PWM period. The block is synchronised to the PWM's period interrupt and forces a safe zero duty on a fault input.

---
 rtl/dcmg_pkg.sv | 15 +
 rtl/period_tick.sv | 28 ++
 rtl/duty_ramp_ctrl.sv | 119 +++++++++++
 tb/tb_duty_ramp_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dcmg_pkg.sv
// Shared definitions for the DC motor/generator (DCMG) PWM controllers.
//   DUTY_W : width of duty/target words
//   DMAX   : largest legal duty, equal to the PWM period count
//   state_e: ramp sequencer states
package dcmg_pkg;
  localparam int DUTY_W = 10;
  localparam int DMAX   = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;
endpackage

// File: rtl/period_tick.sv
// PWM period tick: one-cycle pulse on a rising edge of the PWM period irq.
//   clk  : system clock
//   rst  : async active-high reset
//   irq  : PWM period interrupt level
//   tick : single-cycle pulse on each qualified rising edge
module period_tick (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic tick
);
  logic irq_q;
  logic armed_q;

  // armed_q stays low until irq has been seen low once after reset, so an
  // irq already high when reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      irq_q   <= irq;
      armed_q <= armed_q | ~irq;
    end
  end

  assign tick = irq & ~irq_q & armed_q;
endmodule

// File: rtl/duty_ramp_ctrl.sv
// Soft-start / soft-stop duty sequencer for the DCMG PWM stage.
// Ramps the duty word toward the (clamped) target by STEP once per PWM
// period, synchronised to the PWM period irq; a fault forces zero duty.
//   clk, rst      : clock, async active-high reset
//   enable        : run request (level)
//   target        : commanded duty, clamped to DMAX
//   pwm_irq       : PWM period interrupt, rising edge = period boundary
//   fault         : fault level, highest priority
//   fault_clr     : acknowledge pulse for a latched fault
//   duty, pwm_en  : PWM duty word and enable
//   busy          : ramping
//   at_target     : holding at target
//   fault_latched : in fault state
module duty_ramp_ctrl #(
  parameter int DUTY_W = dcmg_pkg::DUTY_W,
  parameter int DMAX   = dcmg_pkg::DMAX,
  parameter int STEP   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target,
  input  logic              pwm_irq,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_en,
  output logic              busy,
  output logic              at_target,
  output logic              fault_latched
);
  import dcmg_pkg::*;

  localparam logic [DUTY_W-1:0] DMAX_W = DUTY_W'(DMAX);
  localparam logic [DUTY_W-1:0] STEP_W = DUTY_W'(STEP);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt;
  logic [DUTY_W-1:0] step_val;
  logic              tick;

  period_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .irq  (pwm_irq),
    .tick (tick)
  );

  assign tgt = !enable ? '0 : ((target > DMAX_W) ? DMAX_W : target);

  // Move one step toward tgt without overshoot. Comparing the remaining
  // distance against STEP avoids both unsigned wrap and width overflow.
  always_comb begin
    step_val = duty_q;
    if (duty_q < tgt)
      step_val = ((tgt - duty_q) > STEP_W) ? duty_q + STEP_W : tgt;
    else if (duty_q > tgt)
      step_val = ((duty_q - tgt) > STEP_W) ? duty_q - STEP_W : tgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (fault) begin
      state_d = FAULT;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d = '0;
          if (tick && tgt != '0) begin
            state_d = RAMP;
            duty_d  = step_val;
          end
        end
        RAMP: begin
          if (tick) begin
            duty_d = step_val;
            if (step_val == tgt)
              state_d = (tgt == '0) ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (tick && tgt != duty_q) begin
            state_d = RAMP;
            duty_d  = step_val;
          end
        end
        FAULT: begin
          duty_d = '0;
          if (fault_clr) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    duty          = duty_q;
    pwm_en        = (state_q == RAMP) || (state_q == HOLD);
    busy          = (state_q == RAMP);
    at_target     = (state_q == HOLD);
    fault_latched = (state_q == FAULT);
  end
endmodule

// File: tb/tb_duty_ramp_ctrl.sv
module tb_duty_ramp_ctrl;
  localparam int DUTY_W = 10;
  localparam int PER    = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [DUTY_W-1:0] target;
  logic              pwm_irq;
  logic              fault;
  logic              fault_clr;
  logic [DUTY_W-1:0] duty;
  logic              pwm_en, busy, at_target, fault_latched;

  int checks = 0;
  int errors = 0;

  duty_ramp_ctrl #(.DUTY_W(DUTY_W), .DMAX(100), .STEP(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .target        (target),
    .pwm_irq       (pwm_irq),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .duty          (duty),
    .pwm_en        (pwm_en),
    .busy          (busy),
    .at_target     (at_target),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One PWM period: irq high for one cycle, returns sampled just after the
  // tick edge, then idles out the rest of the period.
  task automatic period();
    @(negedge clk) pwm_irq = 1'b1;
    @(negedge clk) pwm_irq = 1'b0;
  endtask

  task automatic idle_rest();
    repeat (PER - 2) @(negedge clk);
  endtask

  initial begin
    int exp_up [5] = '{5, 10, 15, 20, 23};
    int exp_dn [5] = '{18, 13, 8, 3, 0};
    rst = 1'b1; enable = 1'b0; target = '0; pwm_irq = 1'b0;
    fault = 1'b0; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_en", pwm_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_at", at_target, 0);
    chk("rst_flt", fault_latched, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // soft start
    enable = 1'b1; target = 10'd23;
    repeat (2) @(negedge clk);
    chk("ss_en_pre", pwm_en, 0);
    chk("ss_duty_pre", duty, 0);
    for (int i = 0; i < 5; i++) begin
      period();
      chk($sformatf("ss_duty%0d", i), duty, exp_up[i]);
      chk($sformatf("ss_en%0d", i), pwm_en, 1);
      chk($sformatf("ss_busy%0d", i), busy, (i < 4) ? 1 : 0);
      chk($sformatf("ss_at%0d", i), at_target, (i == 4) ? 1 : 0);
      idle_rest();
    end

    // soft stop
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      period();
      chk($sformatf("sp_duty%0d", i), duty, exp_dn[i]);
      idle_rest();
    end
    chk("sp_en", pwm_en, 0);
    chk("sp_busy", busy, 0);
    chk("sp_at", at_target, 0);

    // clamp to DMAX
    enable = 1'b1; target = 10'd1000;
    for (int i = 1; i <= 22; i++) begin
      period();
      chk($sformatf("cl_duty%0d", i), duty, (5 * i > 100) ? 100 : 5 * i);
      idle_rest();
    end
    chk("cl_at", at_target, 1);
    // no irq: duty frozen
    repeat (300) @(negedge clk);
    chk("cl_frozen", duty, 100);

    // ramp back to 0
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin period(); idle_rest(); end
    chk("dn_duty", duty, 0);
    chk("dn_en", pwm_en, 0);

    // retarget mid-ramp
    enable = 1'b1; target = 10'd23;
    period(); idle_rest();
    period();
    chk("rt_d10", duty, 10);
    idle_rest();
    target = 10'd7;
    period();
    chk("rt_d7", duty, 7);
    chk("rt_at", at_target, 1);
    chk("rt_busy", busy, 0);
    idle_rest();
    // target change between ticks has no effect until a tick
    target = 10'd40;
    repeat (20) @(negedge clk);
    chk("rt_between", duty, 7);
    enable = 1'b0;
    period(); chk("rt_d2", duty, 2); idle_rest();
    period(); chk("rt_d0", duty, 0); idle_rest();

    // fault in RAMP at 15, coincident with a tick
    enable = 1'b1; target = 10'd23;
    for (int i = 0; i < 3; i++) begin period(); idle_rest(); end
    chk("ft_pre", duty, 15);
    chk("ft_pre_busy", busy, 1);
    @(negedge clk) begin pwm_irq = 1'b1; fault = 1'b1; end
    @(negedge clk);
    chk("ft_duty", duty, 0);
    chk("ft_en", pwm_en, 0);
    chk("ft_lat", fault_latched, 1);
    pwm_irq = 1'b0; fault_clr = 1'b1;
    @(negedge clk) fault_clr = 1'b0;
    @(negedge clk) fault = 1'b0;
    chk("ft_clr_ign", fault_latched, 1);
    repeat (5) @(negedge clk);
    chk("ft_hold", fault_latched, 1);
    period();
    chk("ft_tick_duty", duty, 0);
    chk("ft_tick_lat", fault_latched, 1);
    @(negedge clk) fault_clr = 1'b1;
    @(negedge clk) fault_clr = 1'b0;
    chk("ft_cleared", fault_latched, 0);
    chk("ft_idle_en", pwm_en, 0);
    idle_rest();
    period();
    chk("ft_restart", duty, 5);
    chk("ft_restart_en", pwm_en, 1);
    idle_rest();

    // async reset mid-ramp
    period();
    chk("ar_pre", duty, 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_duty", duty, 0);
    chk("ar_en", pwm_en, 0);
    chk("ar_busy", busy, 0);
    pwm_irq = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("ar_notick", duty, 0);
    chk("ar_notick_en", pwm_en, 0);
    pwm_irq = 1'b0;
    period();
    chk("ar_tick", duty, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
